// File: rtl/dmem_lsu_pkg.sv
// Shared types and lane helpers for the RV32 data memory load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   // Shift the addressed lane down to bit 0, then extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  funct3);
      logic [31:0] sh;
      sh = word >> {addr_lo, 3'b000};
      case (funct3)
         F3_B:    return {{24{sh[7]}}, sh[7:0]};
         F3_H:    return {{16{sh[15]}}, sh[15:0]};
         F3_W:    return sh;
         F3_BU:   return {24'h0, sh[7:0]};
         F3_HU:   return {16'h0, sh[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [1:0] addr_lo,
                                             input logic [2:0] funct3);
      case (funct3)
         F3_B:    return 4'b0001 << addr_lo;
         F3_H:    return addr_lo[1] ? 4'b1100 : 4'b0011;
         F3_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lsu_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous read port.
module byte_lane_ram #(
   parameter int MEM_WORDS = 256,
   localparam int AW = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] RAM [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) RAM[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = RAM[addr];

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with load/store unit: error decode, lane handling, latency FSM.
// Handshake: a request moves on a rising edge where req_valid & req_ready; the
// response is a single-cycle resp_valid strobe with no backpressure.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int LATENCY   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   localparam int             AW          = $clog2(MEM_WORDS);
   localparam logic [29:0]    WORD_LIMIT  = 30'(MEM_WORDS);
   localparam lsu_state_t     START_STATE = (LATENCY == 1) ? RESP : WAIT;
   localparam logic [3:0]     START_CNT   = (LATENCY == 1) ? 4'd0 : 4'(LATENCY - 1);

   lsu_state_t  state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        accept;
   logic        f3_ok, misaligned, out_of_range, req_err;
   logic        ram_we;
   logic [31:0] ram_wdata, ram_rdata;

   assign accept = req_valid & req_ready;

   always_comb begin
      f3_ok = 1'b0;
      case (req_funct3)
         F3_B, F3_H, F3_W: f3_ok = 1'b1;
         F3_BU, F3_HU:     f3_ok = ~req_we;
         default:          f3_ok = 1'b0;
      endcase
   end

   assign misaligned   = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                         ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
   assign out_of_range = req_addr[31:2] >= WORD_LIMIT;
   assign req_err      = ~f3_ok | misaligned | out_of_range;

   // Replicate store data across lanes; the byte enables pick the live ones.
   always_comb begin
      ram_wdata = req_wdata;
      case (req_funct3[1:0])
         2'b00:   ram_wdata = {4{req_wdata[7:0]}};
         2'b01:   ram_wdata = {2{req_wdata[15:0]}};
         default: ram_wdata = req_wdata;
      endcase
   end

   assign ram_we = accept & req_we & ~req_err;

   byte_lane_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (store_mask(req_addr[1:0], req_funct3)),
      .addr  (req_addr[AW+1:2]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            err_q   <= req_err;
            rdata_q <= (req_we | req_err) ? 32'h0
                       : load_extend(ram_rdata, req_addr[1:0], req_funct3);
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = START_STATE;
               cnt_next   = START_CNT;
            end
         end
         WAIT: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) state_next = RESP;
         end
         RESP: begin
            state_next = IDLE;
            if (accept) begin
               state_next = START_STATE;
               cnt_next   = START_CNT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = ((state == IDLE) | (state == RESP)) & ~reset;
      resp_valid = (state == RESP);
      resp_rdata = resp_valid ? rdata_q : 32'h0;
      resp_err   = resp_valid & err_q;
      dbg_state  = state;
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: four instances (latency 1/3/4/7) against a byte-level
// memory model, with a per-cycle compare and literal checks of directed cases.
module tb_dmem_lsu;
   import lsu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset      [4];
   logic        req_valid  [4];
   logic        req_ready  [4];
   logic        req_we     [4];
   logic [2:0]  req_funct3 [4];
   logic [31:0] req_addr   [4];
   logic [31:0] req_wdata  [4];
   logic        resp_valid [4];
   logic [31:0] resp_rdata [4];
   logic        resp_err   [4];
   logic [1:0]  dbg_state  [4];

   int lat [4] = '{1, 3, 4, 7};
   int mw  [4] = '{256, 64, 64, 64};

   dmem_lsu #(.MEM_WORDS(256), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
      .resp_err(resp_err[0]), .dbg_state(dbg_state[0]));
   dmem_lsu #(.MEM_WORDS(64), .LATENCY(3)) dut_l3 (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
      .resp_err(resp_err[1]), .dbg_state(dbg_state[1]));
   dmem_lsu #(.MEM_WORDS(64), .LATENCY(4)) dut_l4 (
      .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
      .resp_err(resp_err[2]), .dbg_state(dbg_state[2]));
   dmem_lsu #(.MEM_WORDS(64), .LATENCY(7)) dut_l7 (
      .clk(clk), .reset(reset[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
      .req_we(req_we[3]), .req_funct3(req_funct3[3]), .req_addr(req_addr[3]),
      .req_wdata(req_wdata[3]), .resp_valid(resp_valid[3]), .resp_rdata(resp_rdata[3]),
      .resp_err(resp_err[3]), .dbg_state(dbg_state[3]));

   // ---------------- behavioural model ----------------
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          pend   [4];
   int          due    [4];
   logic [31:0] exp_rd [4];
   logic        exp_er [4];
   logic [7:0]  mb     [4][1024];

   function automatic void model_access(input int i, input logic we, input logic [2:0] f,
                                        input logic [31:0] a, input logic [31:0] d,
                                        output logic e, output logic [31:0] r);
      int size;
      bit sgn;
      logic [31:0] v;
      size = 0;
      sgn  = 1'b0;
      case (f)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: size = 4;
         3'd4: if (!we) size = 1;
         3'd5: if (!we) size = 2;
         default: size = 0;
      endcase
      e = (size == 0) || ((a % size) != 0) || ((a >> 2) >= 32'(mw[i]));
      r = 32'h0;
      if (!e) begin
         if (we) begin
            for (int b = 0; b < size; b++) mb[i][int'(a) + b] = d[8*b +: 8];
         end else begin
            v = 32'h0;
            for (int b = 0; b < size; b++) v = v | (32'(mb[i][int'(a) + b]) << (8*b));
            if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            r = v;
         end
      end
   endfunction

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 4; i++) begin
         bit rp;
         rp = !reset[i] && (!pend[i] || due[i] == cyc - 1);
         if (pend[i] && due[i] == cyc - 1) pend[i] = 1'b0;
         if (reset[i]) begin
            pend[i] = 1'b0;
         end else if (req_valid[i] && rp) begin
            model_access(i, req_we[i], req_funct3[i], req_addr[i], req_wdata[i],
                         exp_er[i], exp_rd[i]);
            pend[i] = 1'b1;
            due[i]  = cyc + lat[i] - 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [32:0] exp_q [$];
   logic [32:0] got_q [$];
   int watch   = -1;
   int rv_cnt2 = 0;

   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int i = 0; i < 4; i++) begin
            logic ev;
            logic [34:0] e, a;
            ev = pend[i] && due[i] == cyc;
            e  = {ev, ev ? exp_er[i] : 1'b0, ev ? exp_rd[i] : 32'h0,
                  !reset[i] && (!pend[i] || due[i] == cyc)};
            a  = {resp_valid[i], resp_err[i], resp_rdata[i], req_ready[i]};
            total++;
            if (a !== e) begin
               bad++;
               if (bad < 30)
                  $display("FAIL cycle_check inst=%0d cyc=%0d {valid,err,rdata,ready} got=%h exp=%h",
                           i, cyc, a, e);
            end
            if (resp_valid[i] === 1'b1 && i == watch) got_q.push_back({resp_err[i], resp_rdata[i]});
            if (resp_valid[i] === 1'b1 && i == 2) rv_cnt2++;
         end
      end
   end

   task automatic check_lit(input string name, input logic [32:0] got, input logic [32:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, expv);
      end
   endtask

   // ---------------- driver tasks (called at posedge+2) ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_req(input int i, input logic we, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, output int acc);
      logic r;
      acc = -1;
      req_valid[i]  = 1'b1;
      req_we[i]     = we;
      req_funct3[i] = f;
      req_addr[i]   = a;
      req_wdata[i]  = d;
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         r = req_ready[i];
         step();
         if (r === 1'b1) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         total++;
         bad++;
         $display("FAIL req_timeout inst=%0d addr=%h", i, a);
      end
   endtask

   task automatic quiet(input int i, input int n);
      req_valid[i] = 1'b0;
      repeat (n) step();
   endtask

   task automatic wait_resp(input int i, output int c);
      c = -1;
      for (int g = 0; g < 40; g++) begin
         @(negedge clk);
         if (resp_valid[i] === 1'b1) begin
            c = cyc;
            break;
         end
      end
      step();
      if (c < 0) begin
         total++;
         bad++;
         $display("FAIL resp_timeout inst=%0d", i);
      end
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while (got_q.size() < exp_q.size() && guard < 100) begin
         step();
         guard++;
      end
      if (guard >= 100) begin
         total++;
         bad++;
         $display("FAIL %s_timeout got=%0d exp=%0d", name, got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         if (got_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_missing got=none exp=%h", name, exp_q.pop_front());
         end else begin
            check_lit(name, got_q.pop_front(), exp_q.pop_front());
         end
      end
      got_q.delete();
   endtask

   task automatic run_random(input int i);
      int acc, gap;
      logic [31:0] a;
      for (int w = 0; w < 32; w++) do_req(i, 1'b1, F3_W, 32'(w * 4), $urandom, acc);
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) a = 32'(4 * mw[i]) + $urandom_range(0, 255);
         else                           a = $urandom_range(0, 127);
         do_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, acc);
         gap = $urandom_range(0, 2);
         if (gap > 0) quiet(i, gap);
      end
      quiet(i, lat[i] + 2);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int acc, a1, a2, c, rv0;
      for (int i = 0; i < 4; i++) begin
         reset[i] = 1'b1;  req_valid[i] = 1'b0;  req_we[i] = 1'b0;
         req_funct3[i] = 3'd0;  req_addr[i] = 32'h0;  req_wdata[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) reset[i] = 1'b0;

      for (int i = 0; i < 4; i++) run_random(i);

      // byte/half/word round-trip, back-to-back at latency 1
      watch = 0;
      got_q.delete();
      do_req(0, 1'b1, F3_W,  32'h0, 32'h8001_7F80, acc);
      do_req(0, 1'b0, F3_B,  32'h0, 32'h0, acc);
      do_req(0, 1'b0, F3_BU, 32'h0, 32'h0, acc);
      do_req(0, 1'b0, F3_H,  32'h2, 32'h0, acc);
      do_req(0, 1'b0, F3_HU, 32'h2, 32'h0, acc);
      do_req(0, 1'b0, F3_W,  32'h0, 32'h0, acc);
      quiet(0, 1);
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'hFFFF_FF80});
      exp_q.push_back({1'b0, 32'h0000_0080});
      exp_q.push_back({1'b0, 32'hFFFF_8001});
      exp_q.push_back({1'b0, 32'h0000_8001});
      exp_q.push_back({1'b0, 32'h8001_7F80});
      drain("roundtrip");

      // byte-lane stores merged into one word
      do_req(0, 1'b1, F3_W, 32'h40, 32'h1122_3344, acc);
      do_req(0, 1'b1, F3_B, 32'h41, 32'h0000_00AA, acc);
      do_req(0, 1'b1, F3_H, 32'h42, 32'h0000_BEEF, acc);
      do_req(0, 1'b0, F3_W, 32'h40, 32'h0, acc);
      quiet(0, 1);
      repeat (3) exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'hBEEF_AA44});
      drain("lane_store");

      // error responses leave memory untouched
      do_req(0, 1'b1, F3_W,  32'h04, 32'h5555_AAAA, acc);
      do_req(0, 1'b0, F3_W,  32'h06, 32'h0, acc);
      do_req(0, 1'b1, F3_H,  32'h03, 32'h0000_FFFF, acc);
      do_req(0, 1'b1, F3_W,  32'(4 * 256), 32'hDEAD_BEEF, acc);
      do_req(0, 1'b1, F3_BU, 32'h04, 32'h0, acc);
      do_req(0, 1'b0, F3_W,  32'h04, 32'h0, acc);
      do_req(0, 1'b0, F3_W,  32'h00, 32'h0, acc);
      quiet(0, 1);
      exp_q.push_back({1'b0, 32'h0});
      repeat (4) exp_q.push_back({1'b1, 32'h0});
      exp_q.push_back({1'b0, 32'h5555_AAAA});
      exp_q.push_back({1'b0, 32'h8001_7F80});
      drain("errors");
      watch = -1;

      // latency sweep and held requests
      for (int k = 0; k < 3; k++) begin
         int i;
         i = (k == 0) ? 0 : (k == 1) ? 1 : 3;
         quiet(i, 2);
         do_req(i, 1'b0, F3_W, 32'h0, 32'h0, a1);
         req_valid[i] = 1'b0;
         wait_resp(i, c);
         check_lit($sformatf("latency_l%0d", lat[i]), 33'(c - a1 + 1), 33'(lat[i]));
         do_req(i, 1'b0, F3_W, 32'h4, 32'h0, a1);
         do_req(i, 1'b0, F3_W, 32'h8, 32'h0, a2);
         check_lit($sformatf("held_accept_l%0d", lat[i]), 33'(a2 - a1), 33'(lat[i]));
         quiet(i, lat[i] + 2);
      end

      // reset mid-operation, and a prior store surviving reset
      do_req(2, 1'b1, F3_W, 32'h64, 32'h0000_0019, acc);
      quiet(2, 6);
      rv0 = rv_cnt2;
      do_req(2, 1'b0, F3_W, 32'h10, 32'h0, acc);
      req_valid[2] = 1'b0;
      step();
      step();
      reset[2]     = 1'b1;
      req_valid[2] = 1'b1;
      @(negedge clk);
      check_lit("ready_in_reset", {32'h0, req_ready[2]}, 33'd0);
      step();
      step();
      reset[2]     = 1'b0;
      req_valid[2] = 1'b0;
      @(negedge clk);
      check_lit("ready_after_reset", {32'h0, req_ready[2]}, 33'd1);
      step();
      quiet(2, 6);
      check_lit("no_resp_after_reset", 33'(rv_cnt2 - rv0), 33'd0);
      watch = 2;
      got_q.delete();
      do_req(2, 1'b0, F3_W, 32'h64, 32'h0, acc);
      quiet(2, 1);
      exp_q.push_back({1'b0, 32'h0000_0019});
      drain("persist");
      watch = -1;

      quiet(0, 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
